instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of the instruction decoder/controller.
//  Holds the PC and fetches one 32-bit word per request over a simple req/ack memory port.
//  Presents {if_pc, if_instr} with a valid flag until the downstream stage releases it.
//  Accepts branch/jump redirects from the execute stage and squashes fetches already in flight.
// PARAMETERS
//  RESET_PC   32'h8000_0000  PC loaded on reset; bits [1:0] must be 0
//  NOP_INSTR  32'h0000_0013  value driven on if_instr while no valid instruction is held (addi x0,x0,0)
// PORTS
//  clk            in   1   system clock, all state updates on rising edge
//  reset          in   1   synchronous, active-high reset
//  mem_req        out  1   fetch request; held high until mem_ack
//  mem_addr       out  32  word-aligned fetch address, stable while mem_req=1
//  mem_ack        in   1   one-cycle pulse: mem_rdata valid this cycle, request complete
//  mem_rdata      in   32  fetched instruction word
//  redirect_valid in   1   one-cycle pulse: change PC to redirect_pc
//  redirect_pc    in   32  redirect target; bits [1:0] ignored (forced to 0)
//  stall          in   1   downstream not ready; hold current instruction
//  if_valid       out  1   if_pc/if_instr hold a valid instruction for decode
//  if_pc          out  32  address of if_instr
//  if_instr       out  32  instruction word fed to the controller
// BEHAVIOUR
//  Reset values: state=RST, pc=RESET_PC, mem_req=0, mem_addr=RESET_PC, if_valid=0,
//   if_pc=RESET_PC, if_instr=NOP_INSTR, squash=0. Reset wins over every other input.
//  States: RST, FETCH, VALID.
//  RST: mem_req=0; next cycle (reset low) -> FETCH. First mem_req appears 1 cycle after reset drops.
//  FETCH: mem_req=1, mem_addr=pc, if_valid=0, if_instr=NOP_INSTR.
//   - redirect_valid without mem_ack: pc<=redirect_pc&~3, squash<=1; mem_addr stays on the
//     old address (bus request not cancellable) until mem_ack.
//   - mem_ack with squash=1 or redirect_valid: data discarded; pc<=new target (if redirect
//     this cycle) else retained; squash<=0; stay FETCH; next cycle mem_req=1 at new pc.
//   - mem_ack otherwise: if_instr<=mem_rdata, if_pc<=pc, if_valid<=1 -> VALID.
//  VALID: mem_req=0; if_valid/if_pc/if_instr stable.
//   - redirect_valid (priority over stall): if_valid<=0, pc<=redirect_pc&~3 -> FETCH.
//   - else stall=0: pc<=pc+4 -> FETCH (instruction consumed on this edge).
//   - else hold.
//  Latency: mem_ack at cycle N -> if_valid=1 at N+1; earliest next mem_req at N+2.
//  PC arithmetic: 32-bit modulo; 0xFFFF_FFFC+4 = 0x0000_0000; no misalignment trap.
//  mem_ack outside FETCH (e.g. late ack after reset) is ignored.
//  redirect_valid in RST ignored. stall has no effect in FETCH.
//  mem_addr must not change while mem_req=1 and no mem_ack has been seen.
// TESTING
//  1 Reset release, ack 2 cycles after req with 0x00500093 -> mem_addr 0x8000_0000;
//    if_valid=1, if_pc=0x8000_0000, if_instr=0x00500093 cycle after ack; stall=0 -> next mem_addr 0x8000_0004.
//  2 stall=1 for 5 cycles in VALID -> outputs frozen, mem_req=0; stall=0 -> one fetch at pc+4, no duplicate.
//  3 redirect_valid in VALID to 0x8000_0100 (stall=1 same cycle) -> if_valid=0 next cycle,
//    next mem_addr 0x8000_0100; old instruction never re-presented.
//  4 redirect to 0x8000_0203 during FETCH, ack 3 cycles later -> mem_addr unchanged until ack,
//    data discarded (if_valid stays 0), then mem_addr 0x8000_0200.
//  5 redirect_valid coincident with mem_ack -> data discarded; next mem_addr = redirect target.
//  6 reset asserted mid-FETCH, ack arrives after reset -> mem_req=0, if_valid=0, ack ignored;
//    refetch at RESET_PC; also force pc=0xFFFF_FFFC via redirect -> following fetch at 0x0000_0000.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage with req/ack memory port and redirect squash
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] addr_q;
  logic [31:0] instr_q;
  logic        squash;
  logic [31:0] target;
  logic [31:0] pc_inc;
  logic        discard;
  logic        unused_redirect_lsb;

  // Redirect targets are always word aligned; the low bits are dropped.
  assign target              = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign pc_inc              = pc + 32'd4;

  // Returning data is stale if a redirect arrived earlier or arrives with it.
  assign discard = squash | redirect_valid;

  assign mem_req  = (state == ST_FETCH);
  assign mem_addr = addr_q;
  assign if_instr = if_valid ? instr_q : NOP_INSTR;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RST;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: leave FETCH only on a usable ack; leave VALID on redirect or consume.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RST:   state_nxt = ST_FETCH;
      ST_FETCH: if (mem_ack && !discard) state_nxt = ST_VALID;
      ST_VALID: if (redirect_valid || !stall) state_nxt = ST_FETCH;
      default:  state_nxt = ST_RST;
    endcase
  end

  // PC, bus address, squash flag and the presented instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      addr_q   <= RESET_PC;
      if_valid <= 1'b0;
      if_pc    <= RESET_PC;
      instr_q  <= NOP_INSTR;
      squash   <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (mem_ack) begin
            if (discard) begin
              // Drop the word and reissue at the newest PC next cycle.
              pc     <= redirect_valid ? target : pc;
              addr_q <= redirect_valid ? target : pc;
              squash <= 1'b0;
            end else begin
              instr_q  <= mem_rdata;
              if_pc    <= pc;
              if_valid <= 1'b1;
            end
          end else if (redirect_valid) begin
            // The bus request cannot be withdrawn, so addr_q stays put.
            pc     <= target;
            squash <= 1'b1;
          end
        end
        ST_VALID: begin
          if (redirect_valid) begin
            if_valid <= 1'b0;
            pc       <= target;
            addr_q   <= target;
          end else if (!stall) begin
            if_valid <= 1'b0;
            pc       <= pc_inc;
            addr_q   <= pc_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int checks = 0;
  int fails  = 0;

  instr_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    redirect_valid = 1'b1; redirect_pc = 32'h1234_5678;
    tick; tick;
    mem_ack = 1'b0; redirect_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== RST_PC || if_valid !== 1'b0 ||
        if_pc !== RST_PC || if_instr !== NOP) begin
      fails++;
      $display("FAIL reset_state: req=%0b addr=%h valid=%0b pc=%h instr=%h expected 0/%h/0/%h/%h",
               mem_req, mem_addr, if_valid, if_pc, if_instr, RST_PC, RST_PC, NOP);
    end
    tick;
    checks++;
    if (mem_req !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold_req: req=%0b expected 0", mem_req);
    end
  endtask

  task automatic test_basic_fetch;
    reset = 1'b0; stall = 1'b0;
    tick;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== RST_PC || if_valid !== 1'b0) begin
      fails++;
      $display("FAIL first_req: req=%0b addr=%h valid=%0b expected 1/%h/0", mem_req, mem_addr, if_valid, RST_PC);
    end
    tick;
    tick;
    mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
    tick;
    mem_ack = 1'b0;
    checks++;
    if (if_valid !== 1'b1 || if_pc !== RST_PC || if_instr !== 32'h0050_0093 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL first_instr: valid=%0b pc=%h instr=%h req=%0b expected 1/%h/00500093/0",
               if_valid, if_pc, if_instr, mem_req, RST_PC);
    end
    tick;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0004 || if_valid !== 1'b0 || if_instr !== NOP) begin
      fails++;
      $display("FAIL next_fetch: req=%0b addr=%h valid=%0b instr=%h expected 1/80000004/0/%h",
               mem_req, mem_addr, if_valid, if_instr, NOP);
    end
  endtask

  task automatic test_stall;
    stall = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    tick;
    mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h8000_0004 || if_instr !== 32'h1111_1111 || mem_req !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold[%0d]: valid=%0b pc=%h instr=%h req=%0b expected 1/80000004/11111111/0",
                 i, if_valid, if_pc, if_instr, mem_req);
      end
    end
    stall = 1'b0;
    tick;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0008 || if_valid !== 1'b0) begin
      fails++;
      $display("FAIL stall_release: req=%0b addr=%h valid=%0b expected 1/80000008/0", mem_req, mem_addr, if_valid);
    end
  endtask

  task automatic test_redirect_valid;
    stall = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
    tick;
    mem_ack = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    tick;
    redirect_valid = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h8000_0100 || if_instr !== NOP) begin
      fails++;
      $display("FAIL redir_valid: valid=%0b req=%0b addr=%h instr=%h expected 0/1/80000100/%h",
               if_valid, mem_req, mem_addr, if_instr, NOP);
    end
    tick; tick;
    checks++;
    if (if_valid !== 1'b0 || mem_addr !== 32'h8000_0100) begin
      fails++;
      $display("FAIL redir_no_replay: valid=%0b addr=%h expected 0/80000100", if_valid, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h3333_3333;
    tick;
    mem_ack = 1'b0;
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h8000_0100 || if_instr !== 32'h3333_3333) begin
      fails++;
      $display("FAIL redir_target_instr: valid=%0b pc=%h instr=%h expected 1/80000100/33333333", if_valid, if_pc, if_instr);
    end
    stall = 1'b0;
    tick;
  endtask

  task automatic test_redirect_fetch;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0203;
    tick;
    redirect_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0104) begin
      fails++;
      $display("FAIL squash_addr_hold0: req=%0b addr=%h expected 1/80000104", mem_req, mem_addr);
    end
    tick;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0104) begin
      fails++;
      $display("FAIL squash_addr_hold1: req=%0b addr=%h expected 1/80000104", mem_req, mem_addr);
    end
    tick;
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_0001;
    tick;
    mem_ack = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h8000_0200) begin
      fails++;
      $display("FAIL squash_discard: valid=%0b req=%0b addr=%h expected 0/1/80000200", if_valid, mem_req, mem_addr);
    end
    stall = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h4444_4444;
    tick;
    mem_ack = 1'b0;
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h8000_0200 || if_instr !== 32'h4444_4444) begin
      fails++;
      $display("FAIL squash_refetch: valid=%0b pc=%h instr=%h expected 1/80000200/44444444", if_valid, if_pc, if_instr);
    end
    stall = 1'b0;
    tick;
  endtask

  task automatic test_redirect_ack;
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_0002;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0400;
    tick;
    mem_ack = 1'b0; redirect_valid = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h8000_0400) begin
      fails++;
      $display("FAIL redir_with_ack: valid=%0b req=%0b addr=%h expected 0/1/80000400", if_valid, mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    tick;
    mem_ack = 1'b0;
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h8000_0400 || if_instr !== 32'h5555_5555) begin
      fails++;
      $display("FAIL redir_with_ack_next: valid=%0b pc=%h instr=%h expected 1/80000400/55555555", if_valid, if_pc, if_instr);
    end
    tick;
  endtask

  task automatic test_reset_midfetch_and_wrap;
    reset = 1'b1;
    tick;
    checks++;
    if (mem_req !== 1'b0 || if_valid !== 1'b0) begin
      fails++;
      $display("FAIL midfetch_reset: req=%0b valid=%0b expected 0/0", mem_req, if_valid);
    end
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0_0003;
    tick;
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== RST_PC || if_valid !== 1'b0) begin
      fails++;
      $display("FAIL late_ack_ignored: req=%0b addr=%h valid=%0b expected 1/%h/0", mem_req, mem_addr, if_valid, RST_PC);
    end
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_0004;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick;
    mem_ack = 1'b0; redirect_valid = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h6666_6666;
    tick;
    mem_ack = 1'b0;
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_instr !== 32'h6666_6666) begin
      fails++;
      $display("FAIL wrap_instr: valid=%0b pc=%h instr=%h expected 1/fffffffc/66666666", if_valid, if_pc, if_instr);
    end
    tick;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0000) begin
      fails++;
      $display("FAIL wrap_addr: req=%0b addr=%h expected 1/00000000", mem_req, mem_addr);
    end
  endtask

  // Random traffic against an architectural model: the model tracks the program
  // counter, whether a bus request is outstanding, whether its reply is stale,
  // and whether an instruction is being presented.
  task automatic test_random;
    logic [31:0] m_pc, m_addr, m_ins, m_ipc, tgt;
    bit m_busy, m_have, m_drop;
    bit r_reset, r_ack, r_redir, r_stall;
    logic [31:0] r_data, r_tgt;
    m_pc = RST_PC; m_addr = RST_PC; m_ins = NOP; m_ipc = RST_PC;
    m_busy = 0; m_have = 0; m_drop = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r_reset = (cyc == 0) || ($urandom_range(0, 299) == 0);
      r_ack   = mem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      r_data  = $urandom;
      r_redir = ($urandom_range(0, 15) == 0);
      r_tgt   = $urandom;
      if ($urandom_range(0, 7) == 0) r_tgt = 32'hFFFF_FFF0 | (r_tgt & 32'hF);
      r_stall = ($urandom_range(0, 2) == 0);
      reset = r_reset; mem_ack = r_ack; mem_rdata = r_data;
      redirect_valid = r_redir; redirect_pc = r_tgt; stall = r_stall;
      tgt = r_tgt & 32'hFFFF_FFFC;
      if (r_reset) begin
        m_pc = RST_PC; m_busy = 0; m_have = 0; m_drop = 0;
      end else if (m_busy) begin
        if (r_ack) begin
          if (m_drop || r_redir) begin
            if (r_redir) m_pc = tgt;
            m_drop = 0; m_addr = m_pc;
          end else begin
            m_have = 1; m_busy = 0; m_ins = r_data; m_ipc = m_pc;
          end
        end else if (r_redir) begin
          m_pc = tgt; m_drop = 1;
        end
      end else if (m_have) begin
        if (r_redir) begin
          m_pc = tgt; m_have = 0; m_busy = 1; m_addr = m_pc;
        end else if (!r_stall) begin
          m_pc = m_pc + 32'd4; m_have = 0; m_busy = 1; m_addr = m_pc;
        end
      end else begin
        m_busy = 1; m_addr = m_pc;
      end
      tick;
      checks++;
      if (mem_req !== m_busy || (m_busy && mem_addr !== m_addr) || if_valid !== m_have ||
          (m_have && if_pc !== m_ipc) || if_instr !== (m_have ? m_ins : NOP)) begin
        fails++;
        $display("FAIL random[%0d]: req=%0b addr=%h valid=%0b pc=%h instr=%h expected %0b/%h/%0b/%h/%h",
                 cyc, mem_req, mem_addr, if_valid, if_pc, if_instr,
                 m_busy, m_addr, m_have, m_ipc, m_have ? m_ins : NOP);
      end
    end
    reset = 1'b0; mem_ack = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
  endtask

  initial begin
    test_reset;
    test_basic_fetch;
    test_stall;
    test_redirect_valid;
    test_redirect_fetch;
    test_redirect_ack;
    test_reset_midfetch_and_wrap;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
